// File: rtl/code_dumper_pkg.sv
// Shared constants for the brainfuck toolchain: opcode bytes, the code
// terminator and the code_dumper state encoding.
package code_dumper_pkg;

  localparam logic [7:0] BF_INC   = 8'h2B;
  localparam logic [7:0] BF_DEC   = 8'h2D;
  localparam logic [7:0] BF_PTR_R = 8'h3E;
  localparam logic [7:0] BF_PTR_L = 8'h3C;
  localparam logic [7:0] BF_OUT   = 8'h2E;
  localparam logic [7:0] BF_IN    = 8'h2C;
  localparam logic [7:0] BF_LOOPB = 8'h5B;
  localparam logic [7:0] BF_LOOPE = 8'h5D;
  localparam logic [7:0] BF_TERM  = 8'h00;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_READ      = 3'd2;
  localparam logic [2:0] ST_SEND      = 3'd3;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd4;
  localparam logic [2:0] ST_WAIT_FREE = 3'd5;
  localparam logic [2:0] ST_FIN       = 3'd6;

  function automatic logic is_active_state(input logic [2:0] s);
    return (s != ST_IDLE) && (s != ST_FIN);
  endfunction

endpackage

// File: rtl/code_dumper.sv
// Streams code memory out over the UART tx path, one byte per tx handshake,
// stopping at the terminator byte or at the last address.
module code_dumper
  import code_dumper_pkg::*;
#(
  parameter int addrSize_code = 9
) (
  input  logic                     sysClk,
  input  logic                     reset,
  input  logic                     start,
  output logic [addrSize_code-1:0] addrCode,
  input  logic [7:0]               codeIn,
  input  logic                     tx_ready,
  output logic                     start_transmit,
  output logic [7:0]               data_tx,
  output logic                     busy,
  output logic                     done,
  output logic [addrSize_code:0]   sentCount
);

  localparam logic [addrSize_code:0] CNT_ONE = {{addrSize_code{1'b0}}, 1'b1};
  localparam logic [addrSize_code-1:0] ADDR_ONE = {{(addrSize_code-1){1'b0}}, 1'b1};

  logic [2:0]               r_state;
  logic [addrSize_code-1:0] r_addr;
  logic [addrSize_code:0]   r_cnt;
  logic [7:0]               r_data;
  logic                     r_stx;
  logic                     w_last_addr;

  assign w_last_addr = (r_addr == {addrSize_code{1'b1}});

  always_ff @(posedge sysClk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_stx   <= 1'b0;
    end else begin
      r_stx <= 1'b0;
      case (r_state)
        ST_IDLE, ST_FIN: begin
          if (start) begin
            r_addr  <= '0;
            r_cnt   <= '0;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: r_state <= ST_READ;
        ST_READ: begin
          if (codeIn == BF_TERM) begin
            r_state <= ST_FIN;
          end else begin
            r_data  <= codeIn;
            r_state <= ST_SEND;
          end
        end
        // Pulse is registered, so it is seen during the first WAIT_ACK cycle
        ST_SEND: begin
          if (tx_ready) begin
            r_stx   <= 1'b1;
            r_state <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: if (!tx_ready) r_state <= ST_WAIT_FREE;
        ST_WAIT_FREE: begin
          if (tx_ready) begin
            r_cnt <= r_cnt + CNT_ONE;
            if (w_last_addr) begin
              r_state <= ST_FIN;
            end else begin
              r_addr  <= r_addr + ADDR_ONE;
              r_state <= ST_FETCH;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign addrCode       = r_addr;
  assign sentCount      = r_cnt;
  assign data_tx        = r_data;
  assign start_transmit = r_stx;
  assign busy           = is_active_state(r_state);
  assign done           = (r_state == ST_FIN);

endmodule

// File: tb/tb_code_dumper.sv
// Directed bench for code_dumper: a 9-bit instance with a terminated program
// and a 2-bit instance that runs to the last address.
module tb_code_dumper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start0, start1, hold0;
  logic [8:0] addr0;
  logic [7:0] cin0, dtx0;
  logic       stx0, busy0, done0, txr0;
  logic [9:0] cnt0;
  logic [1:0] addr1;
  logic [7:0] cin1, dtx1;
  logic       stx1, busy1, done1, txr1;
  logic [2:0] cnt1;

  logic [7:0] mem0 [512];
  logic [7:0] mem1 [4];

  int n_chk = 0;
  int n_err = 0;

  code_dumper #(.addrSize_code(9)) u_dut0 (
    .sysClk(clk), .reset(reset), .start(start0), .addrCode(addr0), .codeIn(cin0),
    .tx_ready(txr0), .start_transmit(stx0), .data_tx(dtx0), .busy(busy0),
    .done(done0), .sentCount(cnt0)
  );

  code_dumper #(.addrSize_code(2)) u_dut1 (
    .sysClk(clk), .reset(reset), .start(start1), .addrCode(addr1), .codeIn(cin1),
    .tx_ready(txr1), .start_transmit(stx1), .data_tx(dtx1), .busy(busy1),
    .done(done1), .sentCount(cnt1)
  );

  // synchronous-read code memories, one cycle latency
  always @(posedge clk) begin
    cin0 <= mem0[addr0];
    cin1 <= mem1[addr1];
  end

  // UART echo: ready drops 3 cycles after a pulse and returns 10 cycles later
  logic utx0 = 1'b1, utx1 = 1'b1;
  int   ucnt0 = 0, ucnt1 = 0;
  assign txr0 = utx0 & ~hold0;
  assign txr1 = utx1;

  always @(negedge clk) begin
    if (ucnt0 == 0) begin
      if (stx0) ucnt0 <= 1;
    end else if (ucnt0 == 13) begin
      utx0 <= 1'b1; ucnt0 <= 0;
    end else begin
      if (ucnt0 == 3) utx0 <= 1'b0;
      ucnt0 <= ucnt0 + 1;
    end
  end

  always @(negedge clk) begin
    if (ucnt1 == 0) begin
      if (stx1) ucnt1 <= 1;
    end else if (ucnt1 == 13) begin
      utx1 <= 1'b1; ucnt1 <= 0;
    end else begin
      if (ucnt1 == 3) utx1 <= 1'b0;
      ucnt1 <= ucnt1 + 1;
    end
  end

  // pulse monitors: record each sent byte, count back-to-back pulses
  logic [7:0] q0[$], q1[$];
  logic prev0 = 1'b0, prev1 = 1'b0;
  int   dbl = 0;
  always @(negedge clk) begin
    if (stx0) begin
      q0.push_back(dtx0);
      if (prev0) dbl <= dbl + 1;
    end
    if (stx1) begin
      q1.push_back(dtx1);
      if (prev1) dbl <= dbl + 1;
    end
    prev0 <= stx0;
    prev1 <= stx1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(input int which);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    tick(1);
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int maxc, output int cyc);
    cyc = 0;
    while (cyc < maxc && !((which == 0) ? done0 : done1)) begin
      tick(1);
      cyc++;
    end
  endtask

  function automatic logic [31:0] qb0(input int i);
    if (i < q0.size()) return {24'h0, q0[i]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] qb1(input int i);
    if (i < q1.size()) return {24'h0, q1[i]};
    return 32'hFFFF_FFFF;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int w;
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; hold0 = 1'b0;
    for (int i = 0; i < 512; i++) mem0[i] = 8'h00;
    mem0[0] = 8'h2B; mem0[1] = 8'h2E; mem0[2] = 8'h00;
    mem1[0] = 8'h41; mem1[1] = 8'h42; mem1[2] = 8'h43; mem1[3] = 8'h44;

    // reset state
    tick(3);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_stx",  stx0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_cnt",  cnt0, 0);
    chk("rst_dtx",  dtx0, 0);
    reset = 1'b0;
    tick(2);

    // two bytes then terminator
    q0.delete();
    pulse_start(0);
    chk("A_busy_run", busy0, 1);
    wait_done(0, 300, c);
    chk("A_done",   done0, 1);
    chk("A_npulse", q0.size(), 2);
    chk("A_b0",     qb0(0), 32'h2B);
    chk("A_b1",     qb0(1), 32'h2E);
    chk("A_cnt",    cnt0, 2);
    chk("A_addr",   addr0, 2);
    chk("A_busy",   busy0, 0);

    // second start while busy is ignored
    q0.delete();
    pulse_start(0);
    tick(8);
    pulse_start(0);
    wait_done(0, 300, c);
    chk("B_done",   done0, 1);
    chk("B_npulse", q0.size(), 2);
    chk("B_cnt",    cnt0, 2);
    tick(5);
    chk("B_stay",   done0, 1);

    // terminator at address 0
    mem0[0] = 8'h00;
    q0.delete();
    pulse_start(0);
    wait_done(0, 2, c);
    chk("C_done",   done0, 1);
    chk("C_npulse", q0.size(), 0);
    chk("C_cnt",    cnt0, 0);
    mem0[0] = 8'h2B;

    // tx_ready held low at start
    hold0 = 1'b1;
    q0.delete();
    pulse_start(0);
    tick(20);
    chk("D_nopulse", q0.size(), 0);
    chk("D_busy",    busy0, 1);
    hold0 = 1'b0;
    tick(6);
    chk("D_one",     q0.size(), 1);
    wait_done(0, 300, c);
    chk("D_done",    done0, 1);
    chk("D_npulse",  q0.size(), 2);

    // reset during WAIT_FREE of the first byte
    q0.delete();
    pulse_start(0);
    w = 0;
    while (q0.size() == 0 && w < 50) begin tick(1); w++; end
    chk("E_first", q0.size(), 1);
    tick(5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("E_addr", addr0, 0);
    chk("E_dtx",  dtx0, 0);
    chk("E_cnt",  cnt0, 0);
    chk("E_stx",  stx0, 0);
    chk("E_busy", busy0, 0);
    chk("E_done", done0, 0);
    tick(20);
    chk("E_nomore", q0.size(), 1);
    q0.delete();
    pulse_start(0);
    wait_done(0, 300, c);
    chk("E_redone", done0, 1);
    chk("E_b0",     qb0(0), 32'h2B);
    chk("E_b1",     qb0(1), 32'h2E);
    chk("E_cnt2",   cnt0, 2);

    // full memory, no terminator, 2-bit address
    q1.delete();
    pulse_start(1);
    wait_done(1, 300, c);
    chk("F_done",   done1, 1);
    chk("F_npulse", q1.size(), 4);
    chk("F_b0",     qb1(0), 32'h41);
    chk("F_b1",     qb1(1), 32'h42);
    chk("F_b2",     qb1(2), 32'h43);
    chk("F_b3",     qb1(3), 32'h44);
    chk("F_addr",   addr1, 3);
    chk("F_cnt",    cnt1, 4);

    // start held in FIN restarts the dump
    start1 = 1'b1;
    tick(1);
    chk("F_restart", busy1, 1);
    start1 = 1'b0;
    wait_done(1, 300, c);
    chk("F_redone", done1, 1);
    chk("F_total",  q1.size(), 8);
    chk("F_b4",     qb1(4), 32'h41);

    chk("no_double_pulse", dbl, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
